// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the parametrised main memory.
// Localparams reflect the default build; the functions size other builds.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_LATENCY     = 4;
  localparam int OFF_W           = $clog2(DEF_BLOCK_WORDS);
  localparam int CNT_W           = $clog2(DEF_LATENCY + 1);

  function automatic int off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

  // Bit position of word k inside an assembled cache line.
  function automatic int word_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/main_memory_param_if.sv
// Request/response bundle between the cache controller (master) and main memory (slave).
// Requests are level signals; ready is a one-cycle completion pulse.
interface main_memory_param_if #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) ();

  logic                          read_main;
  logic                          write_main;
  logic [ADDR_W-1:0]             address;
  logic [DATA_W-1:0]             wdata;
  logic [DATA_W/8-1:0]           wstrb;
  logic                          ready;
  logic                          busy;
  logic [DATA_W*BLOCK_WORDS-1:0] data_block;

  modport master (
    output read_main, write_main, address, wdata, wstrb,
    input  ready, busy, data_block
  );

  modport slave (
    input  read_main, write_main, address, wdata, wstrb,
    output ready, busy, data_block
  );

endinterface

// File: rtl/mem_array_be.sv
// Byte-enabled word store: one synchronous write port, BLOCK_WORDS combinational line taps.
// Taps forward an in-progress write so a same-edge read sees the new word.
module mem_array_be
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W/8-1:0]           wstrb,
  input  logic [ADDR_W-1:0]             raddr,
  output logic [DATA_W*BLOCK_WORDS-1:0] rline
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] base;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [LANES-1:0]  strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= lane_merge(mem[waddr], wdata, wstrb);
  end

  // Block base drops the offset bits, so every tap stays inside the array.
  assign base = raddr & ~ADDR_W'(BLOCK_WORDS - 1);

  always_comb begin
    rline = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (we && (waddr == (base | ADDR_W'(k))))
        rline[word_lsb(k, DATA_W) +: DATA_W] = lane_merge(mem[base | ADDR_W'(k)], wdata, wstrb);
      else
        rline[word_lsb(k, DATA_W) +: DATA_W] = mem[base | ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/main_memory_param.sv
// Main memory controller: captures one request, waits LATENCY cycles, commits/loads, pulses ready.
// No queueing: inputs are ignored while busy; a request held through ready starts a new transaction.
module main_memory_param
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input logic              clk,
  input logic              rst,
  main_memory_param_if.slave bus
);

  localparam int CNT_BITS = cnt_w(LATENCY);

  state_t                        state, state_nxt;
  logic [CNT_BITS-1:0]           cnt;
  logic                          req_rd, req_wr;
  logic [ADDR_W-1:0]             req_addr;
  logic [DATA_W-1:0]             req_wdata;
  logic [DATA_W/8-1:0]           req_wstrb;
  logic                          ready_q, busy_q;
  logic [DATA_W*BLOCK_WORDS-1:0] line_q, rline;
  logic                          commit;
  logic                          mem_we;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: if (bus.read_main || bus.write_main) state_nxt = WAIT;
      WAIT: if (cnt == '0) begin
        state_nxt = DONE;
        commit    = 1'b1;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A reset landing on the commit edge must leave the array untouched.
  assign mem_we = commit && req_wr && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      line_q    <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.read_main || bus.write_main) begin
          req_rd    <= bus.read_main;
          req_wr    <= bus.write_main;
          req_addr  <= bus.address;
          req_wdata <= bus.wdata;
          req_wstrb <= bus.wstrb;
          cnt       <= CNT_BITS'(LATENCY - 1);
          busy_q    <= 1'b1;
        end
        WAIT: if (commit) begin
          ready_q <= 1'b1;
          if (req_rd) line_q <= rline;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mem_array_be #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(req_addr),
    .wdata(req_wdata),
    .wstrb(req_wstrb),
    .raddr(req_addr),
    .rline(rline)
  );

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.data_block = line_q;

endmodule
